pulse_channel_scheduler: RTL
============================

PULSE_CHANNEL_SCHEDULER -- requirements
Module: pulse_channel_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of event requesters sharing one slow-to-fast pulse channel; legal range 2..16.
REQ-002 Parameter GAP, default 2, number of idle clk1 cycles forced after every issued pulse; legal range 1..15; elaboration error outside range.
REQ-003 clk1  input  1  single clock (slow domain); all logic on posedge clk1.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  N_REQ  per-requester single-cycle event strobes.
REQ-006 pend  output  N_REQ  registered pending-event flags.
REQ-007 pulse_out  output  1  registered one-cycle pulse to the shared pulse synchronizer input.
REQ-008 pulse_id  output  clog2(N_REQ)  index of the requester served by the current pulse_out; valid only while pulse_out=1, else 0.
REQ-009 overflow  output  1  registered one-cycle flag: an event was merged into an already-pending one.
REQ-010 busy  output  1  high whenever the FSM is in FIRE or GAP.

Function
REQ-011 The block SHALL set pend[i] on the edge that samples req[i]=1.
REQ-012 The FSM SHALL have states IDLE, FIRE, GAP; the reset state is IDLE.
REQ-013 In IDLE with pend!=0, the next edge SHALL enter FIRE, set pulse_out=1 and pulse_id=winner, and clear pend[winner].
REQ-014 FIRE SHALL last exactly one cycle, then enter GAP with pulse_out=0.
REQ-015 GAP SHALL last exactly GAP cycles; on its final edge the FSM SHALL enter FIRE directly if pend!=0, else IDLE.
REQ-016 Consecutive pulse_out rising edges SHALL be spaced exactly GAP+1 cycles under continuous load; pulse_out SHALL never be high two consecutive cycles.
REQ-017 Latency from req[i] sampled in idle system to pulse_out=1 SHALL be 2 edges (pend set, then FIRE).
REQ-018 The winner SHALL be chosen round-robin: the search starts at index ptr, ptr resets to 0, and ptr becomes winner+1 mod N_REQ on every grant.
REQ-019 If req[i]=1 on the same edge that pend[i] is cleared by a grant, pend[i] SHALL remain set and overflow SHALL stay 0.
REQ-020 If req[i]=1 while pend[i]=1 and i is not being granted, the event SHALL be merged (pend[i] stays 1) and overflow SHALL be 1 for the following cycle.
REQ-021 Multiple simultaneous req bits SHALL all be captured in pend on the same edge.

Reset
REQ-022 On reset=1 at an edge: pend=0, pulse_out=0, pulse_id=0, overflow=0, busy=0, ptr=0, state=IDLE, GAP counter=0, regardless of state.
REQ-023 req SHALL be ignored on any edge where reset=1; a pulse in flight SHALL be truncated to its current cycle.

Configuration
REQ-024 Macro PULSE_SCHED_OVF_CNT_EN defined: an extra output ovf_count (8 bits) SHALL count overflow events, saturate at 255, and reset to 0.
REQ-025 Macro PULSE_SCHED_OVF_CNT_EN undefined: no ovf_count port or counter logic SHALL exist; all other behaviour is identical.

Structure
REQ-026 Shared package pulse_sched_pkg SHALL hold the state enum (IDLE, FIRE, GAP), default N_REQ/GAP constants, and the overflow-counter width.
REQ-027 Round-robin selection SHALL live in sub-module rr_pick (inputs pend, ptr; outputs winner index, any_valid), purely combinational.

Verification
REQ-028 N_REQ=4, GAP=2: single req[2] pulse at cycle 3 -> pend[2]=1 at 4, pulse_out=1 with pulse_id=2 at 5, busy 5..7, IDLE at 8.
REQ-029 req=4'b1111 at one edge with ptr=0 -> pulses with ids 0,1,2,3 at cycles t+2, t+5, t+8, t+11; no overflow.
REQ-030 req[1] held high 6 cycles in IDLE -> one pulse id 1, overflow pulses on cycles where pend[1] already set and not granted, re-pend on the grant edge, second pulse GAP+1 later.
REQ-031 Reset asserted during FIRE -> pulse_out=0, pend=0, state IDLE next edge; req sampled with reset=1 is lost.
REQ-032 With PULSE_SCHED_OVF_CNT_EN: 300 merged events -> ovf_count saturates at 255; reset returns it to 0.
REQ-033 Throughout all scenarios, checker asserts pulse_out never high on two consecutive cycles and pulse_id=0 when pulse_out=0.

Source files
------------

// File: rtl/pulse_sched_pkg.sv
// Shared definitions for the pulse channel scheduler: FSM state encoding,
// default sizing constants and the overflow-counter width.
package pulse_sched_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_GAP   = 2;
    localparam int OVF_CNT_W = 8;

    // GAP is also the name of a module parameter, so states carry an S_ prefix.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_GAP  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/pulse_channel_scheduler_rr_pick.sv
// Round-robin picker: returns the first set bit of pend at or after ptr,
// wrapping around to index 0. Purely combinational.
module rr_pick
    import pulse_sched_pkg::*;
#(
    parameter int N   = DEF_N_REQ,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   pend,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] winner,
    output logic           any_valid
);

    // Two ordered passes: first indices >= ptr, then the wrapped-around ones below ptr.
    always_comb begin
        // NOTE: every output gets a default before the loops so no path leaves it unassigned (no latch).
        winner    = '0;
        any_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any_valid && pend[i] && (i >= int'(ptr))) begin
                winner    = IDW'(i);
                any_valid = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any_valid && pend[i] && (i < int'(ptr))) begin
                winner    = IDW'(i);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_channel_scheduler.sv
// Pulse channel scheduler: N_REQ requesters share one pulse channel into a
// pulse synchronizer. Events are latched as pending flags, served round-robin,
// and every issued pulse is followed by GAP forced idle cycles.
// Optional feature: define PULSE_SCHED_OVF_CNT_EN to add a saturating 8-bit
// ovf_count output counting merged (overflowed) events.
module pulse_channel_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int GAP   = DEF_GAP
) (
    input  logic                     clk1,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         pend,
    output logic                     pulse_out,
    output logic [$clog2(N_REQ)-1:0] pulse_id,
    output logic                     overflow,
    output logic                     busy
`ifdef PULSE_SCHED_OVF_CNT_EN
    ,
    output logic [OVF_CNT_W-1:0]     ovf_count
`endif
);

    localparam int IDW = $clog2(N_REQ);
    localparam int GCW = 4;

    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
        $error("pulse_channel_scheduler: N_REQ must be in 2..16");
    end
    if (GAP < 1 || GAP > 15) begin : g_bad_gap
        $error("pulse_channel_scheduler: GAP must be in 1..15");
    end

    sched_state_e     state_q, state_d;
    logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [N_REQ-1:0] pend_q, pend_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             pulse_q, pulse_d;
    logic [IDW-1:0]   pulse_id_q, pulse_id_d;
    logic             ovf_q, ovf_d;
    logic [IDW-1:0]   winner;
    logic             any_valid;
    logic             grant;
    logic [N_REQ-1:0] grant_mask;

    rr_pick #(.N(N_REQ), .IDW(IDW)) u_rr_pick (
        .pend      (pend_q),
        .ptr       (ptr_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk1) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
        if (reset) begin
            state_q    <= S_IDLE;
            gap_cnt_q  <= '0;
            pend_q     <= '0;
            ptr_q      <= '0;
            pulse_q    <= 1'b0;
            pulse_id_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            pend_q     <= pend_d;
            ptr_q      <= ptr_d;
            pulse_q    <= pulse_d;
            pulse_id_q <= pulse_id_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-state logic: grant whenever IDLE or the last GAP cycle finds work pending.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        grant     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    state_d = S_FIRE;
                    grant   = 1'b1;
                end
            end
            S_FIRE: begin
                state_d   = S_GAP;
                gap_cnt_d = GCW'(GAP - 1);
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    if (any_valid) begin
                        state_d = S_FIRE;
                        grant   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and pending bookkeeping: a new req re-arms a bit even as it is granted.
    always_comb begin
        grant_mask = grant ? (N_REQ'(1) << winner) : '0;
        pend_d     = (pend_q & ~grant_mask) | req;
        ovf_d      = |(req & pend_q & ~grant_mask);
        pulse_d    = grant;
        pulse_id_d = grant ? winner : '0;
        ptr_d      = ptr_q;
        if (grant) begin
            ptr_d = (winner == IDW'(N_REQ - 1)) ? '0 : winner + 1'b1;
        end
        busy = (state_q != S_IDLE);
    end

    assign pend      = pend_q;
    assign pulse_out = pulse_q;
    assign pulse_id  = pulse_id_q;
    assign overflow  = ovf_q;

`ifdef PULSE_SCHED_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    // Saturating count of merged events, advanced on the same edge that raises overflow.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_d && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
    end

    // Overflow counter register.
    always_ff @(posedge clk1) begin
        if (reset) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_count = ovf_cnt_q;
`endif

endmodule
